// File: rtl/serial_addsub_unit_pkg.sv
// -----------------------------------------------------------------------------
// serial_addsub_unit_pkg
// Shared definitions for the digit-serial adder/subtractor and its helpers.
//   state_e   : control FSM encoding (IDLE / RUN)
//   MODE_ADD  : mode value selecting a + b
//   MODE_SUB  : mode value selecting a - b
//   cnt_width : width of a counter able to index ndig digits (minimum 1 bit)
// -----------------------------------------------------------------------------
package serial_addsub_unit_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // A single-digit operation still needs a 1-bit counter to keep the
  // register declaration legal.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/serial_addsub_unit_digit_adder_cell.sv
// -----------------------------------------------------------------------------
// digit_adder_cell
// Combinational DIGIT_W-bit ripple-carry adder with carry in and carry out.
// Reusable by any serial arithmetic block that processes one digit per clock.
// Ports:
//   i_a, i_b : DIGIT_W-bit addend digits
//   i_cin    : carry into bit 0
//   o_sum    : DIGIT_W-bit sum digit
//   o_cout   : carry out of the top bit
// -----------------------------------------------------------------------------
module digit_adder_cell
  import serial_addsub_unit_pkg::*;
#(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] i_a,
  input  logic [DIGIT_W-1:0] i_b,
  input  logic               i_cin,
  output logic [DIGIT_W-1:0] o_sum,
  output logic               o_cout
);

  logic w_c;

  // Explicit ripple chain: the digit is narrow by design, so the linear
  // carry path is short and maps to the same cells at any DIGIT_W.
  always_comb begin
    o_sum = '0;
    w_c   = i_cin;
    for (int k = 0; k < DIGIT_W; k++) begin
      o_sum[k] = i_a[k] ^ i_b[k] ^ w_c;
      w_c      = (i_a[k] & i_b[k]) | (w_c & (i_a[k] ^ i_b[k]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/serial_addsub_unit.sv
// -----------------------------------------------------------------------------
// serial_addsub_unit
// Digit-serial adder/subtractor. Operands are captured on a start request and
// processed LSB digit first, DIGIT_W bits per clock. Each sum digit is
// streamed out as produced; after the last digit the full result, carry and
// signed-overflow flags are presented and held until the next operation ends.
//
// Handshake: start is sampled on a rising edge only while busy=0; that edge
// captures mode/a_word/b_word and raises busy. busy stays high for NDIG
// cycles; sum_valid marks each digit; done pulses with the final digit. A new
// start may be presented in the done cycle (busy=0 there).
//
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   start     : operation request (ignored while busy)
//   mode      : 0 = a+b, 1 = a-b (captured with start)
//   a_word    : operand A (captured with start)
//   b_word    : operand B (captured with start)
//   busy      : operation in progress
//   sum_digit : current result digit, LSB digit first
//   sum_valid : sum_digit valid this cycle
//   done      : one-cycle pulse, result/carry_out/overflow updated
//   result    : full sum/difference
//   carry_out : add: carry out of MSB; sub: 1 = no borrow
//   overflow  : two's-complement signed overflow
//   dbg_state : current FSM state (ST_IDLE/ST_RUN) for observation
// -----------------------------------------------------------------------------
module serial_addsub_unit
  import serial_addsub_unit_pkg::*;
#(
  parameter int WORD_W  = 16,
  parameter int DIGIT_W = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [WORD_W-1:0]  a_word,
  input  logic [WORD_W-1:0]  b_word,
  output logic               busy,
  output logic [DIGIT_W-1:0] sum_digit,
  output logic               sum_valid,
  output logic               done,
  output logic [WORD_W-1:0]  result,
  output logic               carry_out,
  output logic               overflow,
  output logic               dbg_state
);

  // WORD_W must be a multiple of DIGIT_W.
  localparam int NDIG  = WORD_W / DIGIT_W;
  localparam int CNT_W = cnt_width(NDIG);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [WORD_W-1:0]  r_a;
  logic [WORD_W-1:0]  r_b;
  logic [WORD_W-1:0]  r_acc;
  logic               r_busy;
  logic [DIGIT_W-1:0] r_sum_digit;
  logic               r_sum_valid;
  logic               r_done;
  logic [WORD_W-1:0]  r_result;
  logic               r_carry_out;
  logic               r_overflow;

  logic [DIGIT_W-1:0] w_sum;
  logic               w_cout;
  logic [WORD_W-1:0]  w_acc_next;
  logic               w_last;
  logic               w_ovf;

  digit_adder_cell #(
    .DIGIT_W (DIGIT_W)
  ) u_cell (
    .i_a    (r_a[DIGIT_W-1:0]),
    .i_b    (r_b[DIGIT_W-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // The accumulator fills from the top so that after NDIG digits the first
  // (least significant) digit has arrived at bit 0.
  generate
    if (NDIG == 1) begin : g_acc_single
      assign w_acc_next = w_sum;
    end else begin : g_acc_shift
      assign w_acc_next = {w_sum, r_acc[WORD_W-1:DIGIT_W]};
    end
  endgenerate

  assign w_last = (r_cnt == LAST_DIG);

  // The operands shift right with zero fill, so while the last digit is being
  // added the top bit of the low digit is still the original MSB of A and of
  // the stored (possibly inverted) B. Signed overflow: equal operand signs
  // giving a sum of the other sign.
  assign w_ovf = (r_a[DIGIT_W-1] == r_b[DIGIT_W-1]) &&
                 (w_sum[DIGIT_W-1] != r_a[DIGIT_W-1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_busy      <= 1'b0;
      r_sum_digit <= '0;
      r_sum_valid <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      r_sum_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            r_a     <= a_word;
            r_b     <= (mode == MODE_SUB) ? ~b_word : b_word;
            r_carry <= mode;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum_digit <= w_sum;
          r_sum_valid <= 1'b1;
          r_carry     <= w_cout;
          r_a         <= r_a >> DIGIT_W;
          r_b         <= r_b >> DIGIT_W;
          r_acc       <= w_acc_next;
          r_cnt       <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result    <= w_acc_next;
            r_carry_out <= w_cout;
            r_overflow  <= w_ovf;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign sum_digit = r_sum_digit;
  assign sum_valid = r_sum_valid;
  assign done      = r_done;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule
